// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR
    } tx_state_t;

    localparam int unsigned FRAME_BITS = 10;

    localparam int unsigned DEF_INHIBIT_CYCLES        = 12000;
    localparam int unsigned DEF_START_TIMEOUT_CYCLES  = 1500000;
    localparam int unsigned DEF_PACKET_TIMEOUT_CYCLES = 200000;

    // PS/2 uses odd parity: the bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - two-flop synchronizer with falling-edge detect
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic level_out,
    output logic fall_out
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // shift the raw line through two stages, keep one more for edge history
    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // idle PS/2 lines float high, so reset to 1 to avoid a false edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign level_out = s2_q;
    assign fall_out  = prev_q & ~s2_q;

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES        = DEF_INHIBIT_CYCLES,
    parameter int unsigned START_TIMEOUT_CYCLES  = DEF_START_TIMEOUT_CYCLES,
    parameter int unsigned PACKET_TIMEOUT_CYCLES = DEF_PACKET_TIMEOUT_CYCLES
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe_out,
    output logic       ps2_data_oe_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       error_out
);

    localparam logic [3:0] LAST_IDX = 4'(FRAME_BITS - 1);

    tx_state_t state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pkt_q, pkt_d;
    logic [3:0]  idx_q, idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic clk_oe_q, clk_oe_d;
    logic data_oe_q, data_oe_d;
    logic busy_q, busy_d;
    logic ready_q, ready_d;
    logic done_q, done_d;
    logic error_q, error_d;

    logic clk_lvl, clk_fall;
    logic data_lvl, data_fall_unused;
    logic pkt_exp;

    ps2_sync_edge u_clk_sync (
        .clk       (clk_in),
        .resetn    (rst_in),
        .async_in  (ps2_clk_in),
        .level_out (clk_lvl),
        .fall_out  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk       (clk_in),
        .resetn    (rst_in),
        .async_in  (ps2_data_in),
        .level_out (data_lvl),
        .fall_out  (data_fall_unused)
    );

    assign pkt_exp = (pkt_q >= PACKET_TIMEOUT_CYCLES - 1);

    // host request sequence; timers stop at their limit instead of wrapping
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pkt_d     = pkt_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        case (state_q)
            IDLE: begin
                if (valid_in && ready_q) begin
                    frame_d   = {1'b1, odd_parity(data_in), data_in};
                    cnt_d     = '0;
                    data_oe_d = (INHIBIT_CYCLES <= 32'd1);
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q >= INHIBIT_CYCLES - 1) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d     = cnt_q + 32'd1;
                    // start bit goes out during the final held-clock cycle
                    data_oe_d = (cnt_d == INHIBIT_CYCLES - 1);
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_oe_d = ~frame_q[0];
                    idx_d     = 4'd1;
                    pkt_d     = '0;
                    state_d   = SEND;
                end else if (cnt_q >= START_TIMEOUT_CYCLES - 1) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SEND: begin
                if (pkt_exp) begin
                    state_d = ERR;
                end else begin
                    pkt_d = pkt_q + 32'd1;
                    if (clk_fall) begin
                        data_oe_d = ~frame_q[idx_q];
                        idx_d     = idx_q + 4'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = ACK;
                        end
                    end
                end
            end
            ACK: begin
                if (pkt_exp) begin
                    state_d = ERR;
                end else begin
                    pkt_d = pkt_q + 32'd1;
                    if (clk_fall) begin
                        state_d = data_lvl ? ERR : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (pkt_exp) begin
                    state_d = ERR;
                end else begin
                    pkt_d = pkt_q + 32'd1;
                    if (clk_lvl && data_lvl) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // outputs follow the state being entered so they are registered
        if (state_d inside {IDLE, ACK, WAIT_IDLE, DONE, ERR}) begin
            data_oe_d = 1'b0;
        end
        clk_oe_d = (state_d == INHIBIT);
        busy_d   = (state_d != IDLE);
        ready_d  = (state_d == IDLE);
        done_d   = (state_d == DONE);
        error_d  = (state_d == ERR);
    end

    // state and output registers; reset releases both lines at once
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pkt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2_clk_oe_out  = clk_oe_q;
    assign ps2_data_oe_out = data_oe_q;
    assign busy_out        = busy_q;
    assign ready_out       = ready_q;
    assign done_out        = done_q;
    assign error_out       = error_q;

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter. It is the sending counterpart of ps2_rx and carries commands to the keyboard (set LEDs 0xED, reset 0xFF, echo 0xEE).
- Accepts a byte over a valid/ready handshake and runs the full host-request sequence: inhibit, start, 8 data bits, odd parity, stop, then waits for the device ACK.
- Drives the open-drain PS/2 lines through active-high output-enable (pull-low) signals.
- Sits beside ps2_rx in the keyboard top level. busy_out gates ps2_rx while a frame is in flight.

Parameters:
INHIBIT_CYCLES, 12000, cycles the clock line is held low before the start bit (120 us at 100 MHz).
START_TIMEOUT_CYCLES, 1500000, max cycles from releasing clock to the first device falling edge (15 ms).
PACKET_TIMEOUT_CYCLES, 200000, max cycles from the first falling edge to the ACK edge (2 ms).

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous, active-low reset
data_in  input  8  command byte
valid_in  input  1  byte offered
ready_out  output  1  high only in IDLE; transfer occurs when valid_in&&ready_out
ps2_clk_in  input  1  raw PS/2 clock line (asynchronous)
ps2_data_in  input  1  raw PS/2 data line (asynchronous)
ps2_clk_oe_out  output  1  1 = pull clock line low
ps2_data_oe_out  output  1  1 = pull data line low
busy_out  output  1  high in every state except IDLE
done_out  output  1  one-cycle pulse: frame sent and ACKed
error_out  output  1  one-cycle pulse: NACK or timeout

Behaviour:
- Reset (rst_in==0 at a clock edge): state IDLE, all counters 0. Outputs: both oe 0, busy 0, done 0, error 0, ready 1 from the first cycle after reset.
  - Reset mid-frame aborts immediately, releases both lines, and pulses neither done nor error.
- Line inputs pass through a 2-flop synchronizer. A falling edge is prev==1 && cur==0 on the synchronized clock.
- Shift frame is 10 bits, LSB first: data[7:0], parity = ~^data_in, stop = 1. Latched at acceptance.
- States:
  - IDLE: ready 1. On handshake in cycle T, latch frame and go to INHIBIT. ps2_clk_oe_out=1 from T+1.
  - INHIBIT: clk_oe 1, data_oe 0, count INHIBIT_CYCLES. On the last count, set data_oe=1 (start bit) while clock is still held, then go to REQ.
  - REQ: clk_oe 0, data_oe 1, timer counts START_TIMEOUT_CYCLES. First falling edge: drive frame bit 0 (data_oe = ~bit), bit index = 1, go to SEND, reset the packet timer.
  - SEND: on each falling edge drive frame[idx], idx++. After frame bit 9 (stop, data_oe=0), go to ACK.
  - ACK: data_oe 0, clk_oe 0. On the next falling edge, sample synchronized data: 0 → WAIT_IDLE (ack); 1 → ERR (nack).
  - WAIT_IDLE: wait until synchronized clock and data are both 1, then DONE.
  - DONE: pulse done_out one cycle, then go to IDLE.
  - ERR: release both lines, pulse error_out one cycle, then go to IDLE.
- Timeouts:
  - REQ timer expiry → ERR.
  - Packet timer expiry in SEND, ACK or WAIT_IDLE → ERR.
  - Timer counters saturate and must not wrap.
- valid_in while not ready is ignored; no byte is queued.
- done_out and error_out are never high in the same cycle.
- All outputs are registered.

Decomposition:
- Package ps2_pkg holds:
  - the tx_state_t enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE, ERR);
  - FRAME_BITS=10;
  - default timing constants;
  - the odd-parity function (shared with ps2_rx).
- One sub-module, ps2_sync_edge: 2-flop synchronizer plus falling-edge detector, instantiated twice (clock and data). ps2_rx reuses it.

Test Plan:
Bench uses INHIBIT_CYCLES=100, START_TIMEOUT_CYCLES=2000, PACKET_TIMEOUT_CYCLES=5000. The device BFM clocks at 20 kHz, samples data on the rising edge, and ACKs by driving data low for one clock after stop.
1. Send 0xED → BFM captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one done_out pulse; error_out stays 0; both oe 0 afterward; ready_out 1.
2. Send 0x01 then 0xFF back-to-back (second valid_in held high) → parity 0, then parity 1. Second acceptance occurs only after done_out; BFM receives exactly two frames.
3. BFM NACK (data left high at the ACK clock) on 0xEE → one error_out pulse, no done_out, lines released, state IDLE.
4. BFM never clocks → error_out exactly 100+2000 cycles (±2 for synchronizer) after acceptance; clk_oe high for exactly 100 cycles; data_oe released.
5. rst_in low during SEND at bit 4 → on the next cycle both oe 0, busy 0, ready 1; no done or error pulse; a following 0xF4 send completes normally.
6. BFM stops clocking after bit 5 → error_out when the packet timer hits 5000; lines released.
